// File: rtl/spi_slave_sync.sv
// SPI mode-0 target running entirely in the HCLK domain: oversampled pins drive a
// command decoder that bridges SPI frames to 32-bit rx/tx valid-ready streams.
module spi_slave_sync #(
  parameter int DUMMY_CYCLES = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        spi_clk,
  input  logic        spi_csn,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [1:0]  spi_mode,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        eot,
  output logic        rx_overflow,
  output logic        tx_underrun,
  output logic        cmd_err
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DUMMY, S_RX, S_TX, S_IGNORE} state_t;

  localparam logic [7:0] C_WRITE    = 8'h02;
  localparam logic [7:0] C_QWRITE   = 8'h38;
  localparam logic [7:0] C_READ     = 8'h0B;
  localparam logic [7:0] C_QREAD    = 8'hEB;
  localparam logic [7:0] DUMMY_LAST = 8'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  logic        r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic        r_csn_p0, r_csn_p1, r_csn_p2;
  logic [3:0]  r_sdi_p0, r_sdi_p1;
  logic [1:0]  r_flush;
  logic        r_armed;

  state_t      r_state;
  logic [6:0]  r_cmd;
  logic [7:0]  r_cnt;
  logic        r_quad;
  logic [30:0] r_rx_sh;
  logic [31:0] r_rx_data;
  logic        r_rx_valid;
  logic [31:0] r_tx_sh;
  logic        r_tx_pend;
  logic        r_pre;
  logic        r_tx_ready;
  logic        r_eot;
  logic        r_rx_ovf;
  logic        r_tx_und;
  logic        r_cmd_err;
  logic [1:0]  r_mode;

  logic        w_clk_rise, w_clk_fall, w_csn_rise, w_csn_fall;
  logic [3:0]  w_sdi;
  logic [7:0]  w_cmd_next;
  logic [31:0] w_rx_next;
  logic [31:0] w_tx_shift;
  logic [7:0]  w_last;
  logic        w_tx_on;

  // Synchronizer stages p0/p1, edge-detect stage p2 (clock and chip select only).
  // r_armed blocks a frame already in progress when reset was released.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sclk_p0 <= 1'b0;
      r_sclk_p1 <= 1'b0;
      r_sclk_p2 <= 1'b0;
      r_csn_p0  <= 1'b1;
      r_csn_p1  <= 1'b1;
      r_csn_p2  <= 1'b1;
      r_sdi_p0  <= 4'h0;
      r_sdi_p1  <= 4'h0;
      r_flush   <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_sclk_p0 <= spi_clk;
      r_sclk_p1 <= r_sclk_p0;
      r_sclk_p2 <= r_sclk_p1;
      r_csn_p0  <= spi_csn;
      r_csn_p1  <= r_csn_p0;
      r_csn_p2  <= r_csn_p1;
      r_sdi_p0  <= {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0};
      r_sdi_p1  <= r_sdi_p0;
      if (r_flush != 2'd3) r_flush <= r_flush + 2'd1;
      else if (r_csn_p2)   r_armed <= 1'b1;
    end
  end

  assign w_clk_rise = r_sclk_p1 & ~r_sclk_p2;
  assign w_clk_fall = ~r_sclk_p1 & r_sclk_p2;
  assign w_csn_rise = r_csn_p1 & ~r_csn_p2;
  assign w_csn_fall = ~r_csn_p1 & r_csn_p2;
  assign w_sdi      = r_sdi_p1;
  assign w_cmd_next = {r_cmd, w_sdi[0]};
  assign w_rx_next  = r_quad ? {r_rx_sh[27:0], w_sdi} : {r_rx_sh, w_sdi[0]};
  assign w_tx_shift = r_quad ? {r_tx_sh[27:0], 4'h0} : {r_tx_sh[30:0], 1'b0};
  assign w_last     = r_quad ? 8'd7 : 8'd31;

  // Frame state machine; chip-select rise overrides everything else in the cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_cmd      <= 7'h0;
      r_cnt      <= 8'd0;
      r_quad     <= 1'b0;
      r_rx_sh    <= 31'h0;
      r_rx_data  <= 32'h0;
      r_rx_valid <= 1'b0;
      r_tx_sh    <= 32'h0;
      r_tx_pend  <= 1'b0;
      r_pre      <= 1'b0;
      r_tx_ready <= 1'b0;
      r_eot      <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_tx_und   <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_mode     <= 2'b00;
    end else begin
      r_tx_ready <= 1'b0;
      r_eot      <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (w_csn_rise) begin
        r_state   <= S_IDLE;
        r_mode    <= 2'b00;
        r_tx_sh   <= 32'h0;
        r_tx_pend <= 1'b0;
        r_pre     <= 1'b0;
        r_cnt     <= 8'd0;
        if (r_armed) r_eot <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_csn_fall && r_armed) begin
              r_rx_ovf  <= 1'b0;
              r_tx_und  <= 1'b0;
              r_cmd_err <= 1'b0;
              r_cnt     <= 8'd0;
              r_state   <= S_CMD;
            end
          end
          S_CMD: begin
            if (w_clk_rise) begin
              r_cmd <= w_cmd_next[6:0];
              if (r_cnt == 8'd7) begin
                r_cnt <= 8'd0;
                case (w_cmd_next)
                  C_WRITE: begin
                    r_quad  <= 1'b0;
                    r_state <= S_RX;
                  end
                  C_QWRITE: begin
                    r_quad  <= 1'b1;
                    r_mode  <= 2'b10;
                    r_state <= S_RX;
                  end
                  C_READ, C_QREAD: begin
                    r_quad <= (w_cmd_next == C_QREAD);
                    r_mode <= (w_cmd_next == C_QREAD) ? 2'b01 : 2'b00;
                    if (DUMMY_CYCLES == 0) begin
                      r_state   <= S_TX;
                      r_tx_pend <= 1'b1;
                    end else begin
                      r_state <= S_DUMMY;
                    end
                  end
                  default: begin
                    r_cmd_err <= 1'b1;
                    r_state   <= S_IGNORE;
                  end
                endcase
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_DUMMY: begin
            if (w_clk_rise) begin
              if (r_cnt == DUMMY_LAST) begin
                r_cnt     <= 8'd0;
                r_state   <= S_TX;
                r_tx_pend <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_RX: begin
            if (w_clk_rise) begin
              r_rx_sh <= w_rx_next[30:0];
              if (r_cnt == w_last) begin
                r_cnt <= 8'd0;
                if (!r_rx_valid) begin
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                end else begin
                  r_rx_ovf <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_TX: begin
            // r_cnt==0 marks a load slot; an entry-cycle load absorbs the next fall.
            if (r_tx_pend || (w_clk_fall && r_cnt == 8'd0 && !r_pre)) begin
              if (tx_valid) begin
                r_tx_sh    <= tx_data;
                r_tx_ready <= 1'b1;
              end else begin
                r_tx_sh  <= 32'h0;
                r_tx_und <= 1'b1;
              end
            end
            if (r_tx_pend) begin
              r_tx_pend <= 1'b0;
              if (w_clk_fall) r_cnt <= 8'd1;
              else            r_pre <= 1'b1;
            end else if (w_clk_fall) begin
              if (r_cnt == 8'd0) begin
                r_pre <= 1'b0;
                r_cnt <= 8'd1;
              end else begin
                r_tx_sh <= w_tx_shift;
                r_cnt   <= (r_cnt == w_last) ? 8'd0 : r_cnt + 8'd1;
              end
            end
          end
          S_IGNORE: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_tx_on     = (r_state == S_TX);
  assign spi_sdo0    = w_tx_on & (r_quad ? r_tx_sh[28] : r_tx_sh[31]);
  assign spi_sdo1    = w_tx_on & r_quad & r_tx_sh[29];
  assign spi_sdo2    = w_tx_on & r_quad & r_tx_sh[30];
  assign spi_sdo3    = w_tx_on & r_quad & r_tx_sh[31];
  assign spi_mode    = r_mode;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ready    = r_tx_ready;
  assign eot         = r_eot;
  assign rx_overflow = r_rx_ovf;
  assign tx_underrun = r_tx_underrun_w();
  assign cmd_err     = r_cmd_err;

  function automatic logic r_tx_underrun_w();
    return r_tx_und;
  endfunction

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

SPI target that terminates the bus driven by the APB SPI master, using a single system clock. SPI inputs are oversampled in the HCLK domain, and a command-driven state machine decodes each transaction. Received words are pushed out on a valid/ready stream, and transmit words are pulled from one. It is used as a peripheral-side loopback and bridge target in the SPI subsystem.

## Interface
- DUMMY_CYCLES, 8: spi_clk rising edges skipped after a read command byte (0..255).
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- spi_csn  in  1  chip select, active low.
- spi_sdi0..spi_sdi3  in  1 each  data in; sdi0 only in single mode, sdi3 = nibble MSB in quad mode.
- spi_sdo0..spi_sdo3  out  1 each  data out; sdo0 only in single mode.
- spi_mode  out  2  00 single, 01 quad-tx (slave drives sdo0..3), 10 quad-rx.
- rx_data  out  32  received word.
- rx_valid  out  1  rx_data valid; held until rx_ready.
- rx_ready  in  1  consumer accept.
- tx_data  in  32  word to transmit.
- tx_valid  in  1  tx_data available.
- tx_ready  out  1  one-cycle pop strobe.
- eot  out  1  one-cycle pulse on spi_csn rising edge.
- rx_overflow  out  1  sticky: received word dropped.
- tx_underrun  out  1  sticky: zero word sent for lack of tx_valid.
- cmd_err  out  1  sticky: unknown command byte.

## Operation
- Synchronizer: spi_clk, spi_csn and sdi0..3 each pass through 2 flops. A third flop on spi_clk and spi_csn feeds edge detection. Data are sampled from the synchronized sdi at the detected rising edge.
- Commands are 8 bits, MSB first, always taken on sdi0:
  - 0x02 WRITE: single-bit write.
  - 0x38 QWRITE: quad write.
  - 0x0B READ: single-bit read.
  - 0xEB QREAD: quad read.
- States: IDLE, CMD, DUMMY, RX, TX, IGNORE.
- IDLE: on a spi_csn falling edge, clear the 3 sticky flags, clear the bit counter, go to CMD.
- CMD: shift sdi0 on each spi_clk rise. After the 8th rise:
  - WRITE/QWRITE: go to RX.
  - READ/QREAD: go to DUMMY, or to TX if DUMMY_CYCLES=0.
  - Any other value: set cmd_err, go to IGNORE.
- DUMMY: count DUMMY_CYCLES rises, then go to TX. spi_mode is 01 in DUMMY for QREAD.
- RX: shift 1 bit (single) or 4 bits {sdi3,sdi2,sdi1,sdi0} (quad) per rise, MSB first. A word completes after 32 (single) or 8 (quad) rises.
  - On completion with rx_valid low: load rx_data and assert rx_valid.
  - On completion with rx_valid high: drop the word and set rx_overflow.
  - The bit counter wraps; reception continues.
- TX word load: at TX entry and at each word boundary, on the first spi_clk falling edge (or the TX-entry cycle, whichever is first):
  - tx_valid=1: load the shift register from tx_data and pulse tx_ready.
  - tx_valid=0: load 0 and set tx_underrun.
- TX shifting: on each subsequent falling edge, shift 1 or 4 bits. sdo holds the MSB or nibble until the next fall.
- rx_valid drops the cycle after rx_valid && rx_ready.
- spi_csn rising edge in any state: go to IDLE, discard the partial word, pulse eot, set spi_mode=00, drive sdo=0. A word already presented on rx_valid is kept.
- spi_mode: 10 in RX for QWRITE, 01 in DUMMY/TX for QREAD, 00 otherwise.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer flops reset to spi_csn=1 and spi_clk=0.
- Clock ratio: spi_clk high and low phases must each be ≥ 3 HCLK cycles (master clock divider ≥ 2).
- Edge latency: a detected edge acts 3 HCLK cycles after the pin edge.
- rx_valid rises 4 HCLK cycles after the final spi_clk rise of a word.
- First TX bit on sdo: 1 HCLK cycle after TX entry. It is stable before the master's first data rise.
- tx_ready is exactly 1 cycle wide per word; never asserted outside TX.
- If a spi_csn rising edge and a word completion occur in the same cycle, spi_csn wins and the word is discarded.
- Asynchronous reset mid-transaction returns everything to reset values; the remainder of the SPI frame is ignored until a new spi_csn fall.

## Test plan
- WRITE 0x02 then 0xDEADBEEF, rx_ready=1 -> one rx_valid pulse, rx_data=0xDEADBEEF, eot pulse on spi_csn rise, all flags 0.
- QWRITE 0x38, 2 words 0x12345678/0x9ABCDEF0 in 16 rises -> two rx words in order, spi_mode=10 during data.
- READ 0x0B, DUMMY_CYCLES=8, tx_data=0xA5A5_0F0F valid -> master samples 0xA5A50F0F on sdo0, tx_ready 1 pulse.
- QREAD with tx_valid=0 -> 32 zero bits on sdo0..3, tx_underrun=1, cleared by the next spi_csn fall.
- WRITE of 2 words with rx_ready=0 -> first word held, rx_overflow=1. Command 0x77 -> cmd_err=1, no rx/tx activity.
- spi_csn raised after 13 data bits -> no rx_valid, eot pulse, state IDLE. HRESETn asserted mid-frame -> all outputs 0.
